inst_fetch_unit: RTL
====================

# inst_fetch_unit

Instruction fetch front end that produces the `pc`/`inst`/`inst_valid` stream consumed by the IF/ID pipeline register.

- Owns the PC.
- Issues in-order word reads to the instruction memory/icache port.
- Buffers returned words in a small FIFO and presents them to IF/ID.
- Honours the downstream `stall`, `flush` and branch-redirect signals, and discards in-flight wrong-path responses.

## Interface
- `RESET_PC`, default 32'h1c000000: first fetch address after reset.
- `FIFO_DEPTH`, default 4: instruction buffer entries. Power of two, ≥2. Also the cap on in-flight requests.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: IF/ID holding (`Stop`=1); head entry must not be consumed.
- `flush` in 1: exception/ertn redirect to `flush_pc`.
- `flush_pc` in 32: flush target.
- `branch_flag_i` in 1: branch taken in ID/EX; redirect to `branch_target_i`.
- `branch_target_i` in 32: branch target.
- `icache_req_o` out 1: read request.
- `icache_addr_o` out 32: word address of request.
- `icache_ack_i` in 1: request accepted this cycle (handshake = `req & ack`).
- `icache_rvalid_i` in 1: response word valid; responses strictly in request order, ≥1 cycle after accept.
- `icache_rdata_i` in 32: response instruction.
- `if_pc_o` out 32: PC of head instruction; 0 when invalid.
- `if_inst_o` out 32: head instruction; 0 when invalid.
- `if_inst_valid_o` out 1: head valid (`InstValid`).

## Operation
- **PC.** `pc_r` resets to `RESET_PC`. Advances by 4 on each accepted request. Redirect targets are loaded with bits [1:0] forced to 0.
- **Redirect.** `redirect = flush | branch_flag_i`. `flush` has priority: its target is `flush_pc`, otherwise `branch_target_i`. In a redirect cycle:
  - `pc_r` ← target.
  - FIFO cleared.
  - `icache_req_o` = 0.
  - Any `icache_rvalid_i` that cycle is discarded.
  - `drop_cnt` ← `inflight_cnt` − `icache_rvalid_i`.
- **Issue.** `icache_req_o` = `!rst & !redirect & (inflight_cnt + fifo_count < FIFO_DEPTH)`, with `icache_addr_o` = `pc_r`. Every accepted request therefore has a reserved FIFO slot, so the FIFO cannot overflow. Both counters are `$clog2(FIFO_DEPTH)+1` bits.
- **`inflight_cnt`.** +1 on accept, −1 on `rvalid`; both in the same cycle leaves it unchanged.
- **Response.** If `drop_cnt` > 0, the word is discarded and `drop_cnt` decrements. Otherwise `{pc_of_req, rdata}` is pushed. The request PC comes from a PC tag queue (`FIFO_DEPTH` entries) written on accept and read on response. The tag queue is cleared on redirect only for entries already dropped; in practice it is implemented as tags pushed for every request and popped on every response, including dropped ones.
- **Output.** Head of the FIFO drives `if_pc_o`/`if_inst_o`; `if_inst_valid_o` = FIFO not empty. Pop = `valid & !stall & !redirect`.
- **Simultaneous events.** Push and pop in the same cycle are allowed at any occupancy, including full, since a slot is reserved.
- **Reset mid-operation.** All counters, pointers and `drop_cnt` are cleared. Responses arriving after reset to pre-reset requests are the memory's responsibility: the icache is reset by the same `rst`.

## Timing
- **Reset values.** `icache_req_o`=0, `icache_addr_o`=`RESET_PC`, `if_inst_valid_o`=0, `if_pc_o`=0, `if_inst_o`=0.
- **First request.** Cycle 1 after `rst` deasserts: `req`=1, `addr`=`RESET_PC`.
- **Latency.** A response in cycle N appears on the outputs in cycle N+1 (registered FIFO, no bypass).
- **Best-case throughput.** One instruction per cycle once `icache_ack_i`=1 continuously and the response latency is at most `FIFO_DEPTH`−1.
- **Redirect.** First new-path request is issued the cycle after the redirect. The outputs show invalid in the cycle after the redirect.
- **Stall.** Outputs are held stable while `stall`=1 and no redirect occurs.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - Adds output ports `perf_fetch_cnt_o[31:0]` (accepted requests) and `perf_drop_cnt_o[31:0]` (discarded wrong-path responses).
  - Both are free-running, wrap at 2^32, and reset to 0.
- Undefined: ports and counters are absent; functional behaviour is identical.

## Structure
- Shared `defines.v` holds:
  - `InstAddrBus`, `InstBus`, `ZeroWord`, `Stop`, `InstValid`.
  - New: `` `RESET_PC_DEFAULT `` (32'h1c000000).
- Sub-module `fetch_fifo`: parameterised width/depth synchronous FIFO with clear, push, pop, count, and head data. It is instantiated twice: for the PC tag queue (32b) and for the instruction buffer (64b).

## Test plan
- **Reset release, `ack`=1, fixed 1-cycle memory returning `rdata`=`addr`^32'hFFFF_FFFF:**
  - Requests 1c000000, 1c000004, … issued back to back.
  - Outputs valid from cycle 3 with matching `pc`/`inst`.
- **`stall`=1 for 5 cycles:**
  - Outputs held.
  - `fifo_count` reaches 4; `req` drops once `inflight`+`count`=4.
  - Resumes with no lost or duplicated PC.
- **Branch to 1c000101 with 3 requests in flight:**
  - The 3 responses are dropped.
  - Next request `addr`=1c000100.
  - Next valid output `pc`=1c000100.
- **`flush` and `branch_flag_i` in the same cycle (`flush_pc`=1c008000, branch 1c000200):** fetch resumes at 1c008000.
- **`ack` toggling randomly, response latency 1–4 cycles, 1000 instructions:** the output PC sequence is strictly +4 and every `inst` matches its PC.
- **`rst` asserted mid-stream with a full FIFO:** the next cycle shows `valid`=0 and `req`=0; the cycle after shows `req` at `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared fetch types, constants and helpers
//   RESET_PC_DEFAULT : first fetch address after reset
//   ZERO_WORD        : value driven on invalid pc/inst outputs
//   fetch_entry_t    : {pc, inst} pair held in the instruction buffer
package inst_fetch_unit_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [31:0] ZERO_WORD = 32'h0;
    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;
    typedef struct packed {
        inst_addr_t pc;
        inst_t inst;
    } fetch_entry_t;
    function automatic inst_addr_t word_align(input inst_addr_t a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: fetch unit bus bundle
//   control : stall, flush, flush_pc, branch_flag_i, branch_target_i
//   icache  : icache_req_o, icache_addr_o, icache_ack_i, icache_rvalid_i, icache_rdata_i
//   IF/ID   : if_pc_o, if_inst_o, if_inst_valid_o
//   master = fetch unit side, slave = pipeline/memory side
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;
    logic stall;
    logic flush;
    inst_addr_t flush_pc;
    logic branch_flag_i;
    inst_addr_t branch_target_i;
    logic icache_req_o;
    inst_addr_t icache_addr_o;
    logic icache_ack_i;
    logic icache_rvalid_i;
    inst_t icache_rdata_i;
    inst_addr_t if_pc_o;
    inst_t if_inst_o;
    logic if_inst_valid_o;
    modport master (
        input stall, flush, flush_pc, branch_flag_i, branch_target_i,
        input icache_ack_i, icache_rvalid_i, icache_rdata_i,
        output icache_req_o, icache_addr_o,
        output if_pc_o, if_inst_o, if_inst_valid_o
    );
    modport slave (
        output stall, flush, flush_pc, branch_flag_i, branch_target_i,
        output icache_ack_i, icache_rvalid_i, icache_rdata_i,
        input icache_req_o, icache_addr_o,
        input if_pc_o, if_inst_o, if_inst_valid_o
    );
endinterface

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear, head data and occupancy count
//   clk, rst : clock, synchronous active-high reset
//   clr      : empty the FIFO (overrides push/pop)
//   push/din : write din at tail
//   pop      : drop head entry
//   head     : head entry data
//   count    : number of entries (0..DEPTH)
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d = count_q;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner, in-order icache requester and IF/ID instruction buffer
//   clk, rst : clock, synchronous active-high reset
//   bus      : inst_fetch_unit_if.master (stall/flush/branch in, icache req/resp, IF/ID out)
//   perf_fetch_cnt_o, perf_drop_cnt_o : accepted requests / discarded wrong-path
//                                       responses, present only with IF_PERF_CNT_EN
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    inst_fetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_drop_cnt_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic redirect, accept, drop_now, push, pop, valid;
    inst_addr_t pc_q, pc_d, redirect_pc, tag_pc;
    logic [CW-1:0] drop_q, drop_d, inflight, ibuf_count;
    fetch_entry_t ibuf_head, ibuf_din;

    // Tags are pushed on every accept and popped on every response, dropped or
    // not, so the tag count is exactly the number of requests in flight.
    fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag (
        .clk(clk), .rst(rst), .clr(1'b0),
        .push(accept), .pop(bus.icache_rvalid_i), .din(pc_q),
        .head(tag_pc), .count(inflight)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk(clk), .rst(rst), .clr(redirect),
        .push(push), .pop(pop), .din(ibuf_din),
        .head(ibuf_head), .count(ibuf_count)
    );

    always_comb begin
        redirect = bus.flush | bus.branch_flag_i;
        redirect_pc = word_align(bus.flush ? bus.flush_pc : bus.branch_target_i);
        // A request is only issued when a buffer slot is reserved for its reply.
        bus.icache_req_o = !rst && !redirect && (inflight + ibuf_count < CW'(FIFO_DEPTH));
        accept = bus.icache_req_o & bus.icache_ack_i;
        drop_now = bus.icache_rvalid_i & (redirect | (drop_q != '0));
        push = bus.icache_rvalid_i & !drop_now;
        valid = ibuf_count != '0;
        pop = valid & !bus.stall & !redirect;
        ibuf_din = '{pc: tag_pc, inst: bus.icache_rdata_i};
        pc_d = redirect ? redirect_pc : accept ? pc_q + 32'd4 : pc_q;
        drop_d = redirect ? inflight - CW'(bus.icache_rvalid_i) : drop_q - CW'(drop_now);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q <= pc_d;
            drop_q <= drop_d;
        end
    end

    assign bus.icache_addr_o = pc_q;
    assign bus.if_inst_valid_o = valid;
    assign bus.if_pc_o = valid ? ibuf_head.pc : ZERO_WORD;
    assign bus.if_inst_o = valid ? ibuf_head.inst : ZERO_WORD;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d, perf_drop_q, perf_drop_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(accept);
        perf_drop_d = perf_drop_q + 32'(drop_now);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_drop_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q <= perf_drop_d;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_drop_cnt_o = perf_drop_q;
`endif
endmodule
